// File: rtl/pkt_rr_sched_pkg.sv
// Shared constants for the packet round-robin scheduler: state encoding,
// watchdog defaults and the index-width helper.
package pkt_rr_sched_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_XFER = 1'b1;

  localparam int DEF_TIMEOUT = 255;
  localparam int CNTW        = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping
// modulo NREQ. Purely combinational so other schedulers can share it.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int SRCW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  output logic            any,
  output logic [SRCW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest hit lands last.
  always_comb begin
    int j;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j[SRCW-1:0]]) begin
        any = 1'b1;
        idx = j[SRCW-1:0];
      end
    end
  end

endmodule

// File: rtl/pkt_rr_sched.sv
// Packet-granular round-robin scheduler: holds a grant from first beat to
// last beat, with a stall watchdog that reclaims a grant from a silent owner.
module pkt_rr_sched
  import pkt_rr_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int SRCW    = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    s_valid,
  input  logic [NREQ-1:0]    s_last,
  input  logic [NREQ*DW-1:0] s_data,
  output logic [NREQ-1:0]    s_ready,
  output logic               m_valid,
  output logic               m_last,
  output logic [DW-1:0]      m_data,
  input  logic               m_ready,
  output logic [SRCW-1:0]    m_src,
  output logic               busy,
  output logic               timeout_stb,
  output logic [SRCW-1:0]    timeout_src
);

  if (SRCW != clog2(NREQ)) begin : g_bad_srcw
    $error("SRCW must equal clog2(NREQ)");
  end

  logic            state_q, state_d;
  logic [SRCW-1:0] g_q, ptr_q, ptr_nxt, pick_idx, tsrc_q;
  logic [CNTW-1:0] stall_q;
  logic            pick_any, in_xfer, own_valid, own_last, xfer, stall, fire;
  logic [DW-1:0]   own_data;

  rr_pick #(.NREQ(NREQ), .SRCW(SRCW)) u_pick (
    .req (s_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign in_xfer   = (state_q == ST_XFER);
  assign own_valid = s_valid[g_q];
  assign own_last  = s_last[g_q];
  assign own_data  = s_data[g_q*DW +: DW];
  assign xfer      = in_xfer && own_valid && m_ready;
  // Backpressure (m_ready low) is not the owner's fault, so it never counts.
  assign stall     = in_xfer && !own_valid && m_ready;
  assign fire      = stall && (stall_q == CNTW'(TIMEOUT - 1));
  assign ptr_nxt   = (g_q == SRCW'(NREQ - 1)) ? '0 : g_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_XFER;
      ST_XFER: if ((xfer && own_last) || fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = in_xfer;
    m_valid     = in_xfer && own_valid;
    m_last      = in_xfer && own_last;
    m_data      = in_xfer ? own_data : '0;
    s_ready     = '0;
    if (in_xfer) s_ready[g_q] = m_ready;
    timeout_stb = fire;
    timeout_src = fire ? g_q : tsrc_q;
  end

  assign m_src = g_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q     <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      tsrc_q  <= '0;
    end else begin
      if (!in_xfer && pick_any) g_q <= pick_idx;
      if (!in_xfer || xfer)     stall_q <= '0;
      else if (stall)           stall_q <= stall_q + 1'b1;
      if ((xfer && own_last) || fire) ptr_q <= ptr_nxt;
      if (fire)                 tsrc_q <= g_q;
    end
  end

endmodule

// File: tb/tb_pkt_rr_sched.sv
// Bench for pkt_rr_sched: packet-level reference model checked every cycle,
// plus directed scenarios with hand-derived grant orders and timings.
module tb_pkt_rr_sched;
  localparam int N = 4, DW = 32, SW = 2, TO = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    s_valid, s_last, s_ready;
  logic [N*DW-1:0] s_data;
  logic            m_valid, m_last, m_ready, busy, timeout_stb;
  logic [DW-1:0]   m_data;
  logic [SW-1:0]   m_src, timeout_src;

  pkt_rr_sched #(.NREQ(N), .DW(DW), .SRCW(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_last(s_last),
    .s_data(s_data), .s_ready(s_ready), .m_valid(m_valid), .m_last(m_last),
    .m_data(m_data), .m_ready(m_ready), .m_src(m_src), .busy(busy),
    .timeout_stb(timeout_stb), .timeout_src(timeout_src)
  );

  int tests = 0, fails = 0, cyc = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Source behaviour: each source sends packets of plen beats; maxb caps total
  // beats (then it goes silent), stop makes it quit at a packet boundary.
  bit en[N], stop[N];
  int plen[N], maxb[N], beat[N], sent[N];
  bit rdy_tog;

  // Reference model: owner/pointer/stall count at packet level.
  bit r_busy;
  int r_own, r_ptr, r_stall, r_tsrc;

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 0; r_own <= 0; r_ptr <= 0; r_stall <= 0; r_tsrc <= 0;
    end else if (!r_busy) begin
      if (pick(s_valid, r_ptr) >= 0) begin
        r_busy <= 1; r_own <= pick(s_valid, r_ptr); r_stall <= 0;
      end
    end else if (s_valid[r_own] && m_ready) begin
      r_stall <= 0;
      if (s_last[r_own]) begin r_busy <= 0; r_ptr <= (r_own + 1) % N; end
    end else if (m_ready) begin
      if (r_stall == TO - 1) begin
        r_busy <= 0; r_ptr <= (r_own + 1) % N; r_tsrc <= r_own;
      end else r_stall <= r_stall + 1;
    end
  end

  // Observation logs used by the directed checks.
  int x_src[$], x_cyc[$], grants[$], tcyc[$], tsrcq[$];
  logic [DW-1:0] x_data[$];
  bit x_last[$];
  bit pbusy = 0;

  always @(negedge clk) begin
    logic [N-1:0] e_rdy;
    bit e_stb;
    cyc++;
    e_stb = r_busy && m_ready && !s_valid[r_own] && (r_stall == TO - 1);
    e_rdy = '0;
    if (r_busy) e_rdy[r_own] = m_ready;
    chk("busy", busy, r_busy);
    chk("m_valid", m_valid, r_busy && s_valid[r_own]);
    chk("m_last", m_last, r_busy && s_last[r_own]);
    chk("m_data", m_data, r_busy ? s_data[r_own*DW +: DW] : '0);
    chk("s_ready", s_ready, e_rdy);
    chk("m_src", m_src, r_own);
    chk("timeout_stb", timeout_stb, e_stb);
    chk("timeout_src", timeout_src, e_stb ? r_own : r_tsrc);
    if (m_valid && m_ready) begin
      x_src.push_back(m_src); x_cyc.push_back(cyc);
      x_data.push_back(m_data); x_last.push_back(m_last);
    end
    if (busy && !pbusy) grants.push_back(m_src);
    if (timeout_stb) begin tcyc.push_back(cyc); tsrcq.push_back(timeout_src); end
    pbusy = busy;
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_valid[i] = en[i] && (maxb[i] < 0 || sent[i] < maxb[i]) && !(stop[i] && beat[i] == 0);
      s_last[i]  = (beat[i] == plen[i] - 1);
      s_data[i*DW +: DW] = {8'(i), 24'(sent[i])};
    end
  endtask

  task automatic run(int n);
    bit hs[N];
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) hs[i] = s_valid[i] && s_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (hs[i]) begin sent[i]++; beat[i] = (beat[i] + 1) % plen[i]; end
      if (rdy_tog) m_ready = !m_ready;
      drive();
    end
  endtask

  task automatic setup();
    for (int i = 0; i < N; i++) begin
      en[i] = 0; stop[i] = 0; plen[i] = 1; maxb[i] = -1; beat[i] = 0; sent[i] = 0;
    end
    rdy_tog = 0; m_ready = 1'b1;
    drive();
  endtask

  task automatic clear_logs();
    x_src.delete(); x_cyc.delete(); x_data.delete(); x_last.delete();
    grants.delete(); tcyc.delete(); tsrcq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    setup();
    run(2);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic drain();
    int k = 0;
    for (int i = 0; i < N; i++) stop[i] = 1;
    drive();
    while ((busy || s_valid != '0) && k < 40) begin run(1); k++; end
    chk("drain_bound", k < 40, 1);
  endtask

  initial begin
    int ge[5];
    bit dup;
    int k;
    do_reset();

    // Idle: nothing requests, nothing granted.
    run(16);
    chk("idle_busy", busy, 0);
    chk("idle_src", m_src, 0);
    chk("idle_grants", grants.size(), 0);

    // Sources 0 and 2 alternate with 3-beat packets.
    en[0] = 1; en[2] = 1; plen[0] = 3; plen[2] = 3; drive();
    run(17);
    ge = '{0, 2, 0, 2, 0};
    chk("alt_ngrant", grants.size() >= 4, 1);
    for (int p = 0; p < 4; p++) chk("alt_grant", grants[p], ge[p]);
    chk("alt_nxfer", x_src.size() >= 12, 1);
    for (int b = 0; b < 12; b++) chk("alt_xsrc", x_src[b], ge[b/3]);
    for (int p = 0; p < 4; p++) chk("alt_span", x_cyc[p*3+2] - x_cyc[p*3], 2);
    for (int p = 0; p < 3; p++) chk("alt_gap", x_cyc[p*3+3] - x_cyc[p*3+2], 2);
    drain();

    // Everyone requests, 2-beat packets: strict rotation.
    do_reset();
    for (int i = 0; i < N; i++) begin en[i] = 1; plen[i] = 2; end
    drive();
    run(20);
    ge = '{0, 1, 2, 3, 0};
    chk("rr_ngrant", grants.size() >= 5, 1);
    for (int p = 0; p < 5; p++) chk("rr_grant", grants[p], ge[p]);
    for (int w = 0; w + 3 < grants.size(); w++) begin
      dup = 0;
      for (int a = 0; a < 4; a++)
        for (int b = a + 1; b < 4; b++) if (grants[w+a] == grants[w+b]) dup = 1;
      chk("rr_window", dup, 0);
    end
    drain();

    // Backpressure: m_ready toggles, owner always valid, no watchdog.
    do_reset();
    en[1] = 1; plen[1] = 4; maxb[1] = 4; rdy_tog = 1; drive();
    run(20);
    chk("bp_nxfer", x_src.size(), 4);
    for (int b = 0; b < 4; b++) chk("bp_data", x_data[b], {8'd1, 24'(b)});
    chk("bp_last", x_last[3], 1);
    chk("bp_span", x_cyc[3] - x_cyc[0], 6);
    chk("bp_no_tmo", tcyc.size(), 0);
    rdy_tog = 0; m_ready = 1'b1;
    drain();

    // Watchdog: source 3 sends one non-last beat then goes silent.
    do_reset();
    en[3] = 1; plen[3] = 4; maxb[3] = 1; drive();
    k = 0;
    while (x_src.size() == 0 && k < 10) begin run(1); k++; end
    chk("wd_first_beat", k < 10, 1);
    en[0] = 1; plen[0] = 2; drive();
    run(14);
    chk("wd_ntmo", tcyc.size(), 1);
    chk("wd_delay", tcyc[0] - x_cyc[0], 8);
    chk("wd_src", tsrcq[0], 3);
    chk("wd_src_hold", timeout_src, 3);
    chk("wd_next_grant", grants[1], 0);
    drain();

    // Reset in the middle of source 1's second packet.
    do_reset();
    en[1] = 1; plen[1] = 4; drive();
    k = 0;
    while (sent[1] < 5 && k < 30) begin run(1); k++; end
    chk("mr_reach", k < 30, 1);
    chk("mr_busy_pre", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", m_valid, 0);
    chk("mr_ready", s_ready, 0);
    chk("mr_src", m_src, 0);
    chk("mr_data", m_data, 0);
    setup();
    run(1);
    rst_n = 1'b1;
    clear_logs();
    en[1] = 1; en[3] = 1; plen[1] = 2; plen[3] = 2; drive();
    run(6);
    chk("mr_first_grant", grants[0], 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pkt_rr_sched.md
Name: pkt_rr_sched

Overview:
- Packet-granular round-robin scheduler that shares one output stream among NREQ input streams, e.g. several cell/packet sources feeding a single link TX path.
- Unlike a per-cycle request/grant arbiter, a grant is held from the first accepted beat through the beat marked last.
- A per-packet stall watchdog releases a grant whose owner stops supplying beats.

Parameters:
NREQ, 4, number of requesting input streams (2..16)
DW, 32, data word width in bits
SRCW, 2, width of source index; must equal clog2(NREQ)
TIMEOUT, 255, consecutive stalled cycles in XFER before the grant is forcibly released (1..65535)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  NREQ  per-source beat valid; also serves as the request
s_last  in  NREQ  per-source end-of-packet marker, qualified by s_valid
s_data  in  NREQ*DW  per-source data, source i at [i*DW +: DW]
s_ready  out  NREQ  per-source ready
m_valid  out  1  output beat valid
m_last  out  1  output end-of-packet
m_data  out  DW  output data
m_ready  in  1  downstream ready
m_src  out  SRCW  index of current owner, valid while busy=1
busy  out  1  high in XFER
timeout_stb  out  1  one-cycle pulse when the watchdog fires
timeout_src  out  SRCW  source that timed out; holds until the next timeout

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, ptr=0, grant=0.
  - Outputs at reset: m_valid=0, m_last=0, m_data=0, s_ready=0, m_src=0, busy=0, timeout_stb=0, timeout_src=0, stall counter=0.
- States: IDLE, XFER.
- IDLE:
  - s_ready=0, m_valid=0.
  - If any s_valid is high, pick the first set bit scanning from ptr upward modulo NREQ.
  - On the next edge: register grant index g, set m_src=g, enter XFER. Grant latency is one cycle.
  - If no s_valid is high, stay in IDLE.
- XFER:
  - m_valid=s_valid[g], m_last=s_last[g], m_data=s_data[g], s_ready[g]=m_ready. These are combinational mux paths with no added latency.
  - s_ready of all non-owners is 0.
  - A beat transfers when m_valid and m_ready are both high.
  - On transfer with m_last=1: next state IDLE, ptr=(g+1) mod NREQ. Re-arbitration therefore costs exactly one idle cycle between packets.
- Watchdog:
  - The counter clears on entering XFER and on every transfer.
  - It increments on every XFER cycle where s_valid[g]=0. Cycles where m_ready=0 are downstream backpressure, do not count, and hold the counter.
  - When counter==TIMEOUT-1 and another stalled cycle occurs: timeout_stb=1 for one cycle, timeout_src=g, next state IDLE, ptr=(g+1) mod NREQ.
  - The truncated packet is not terminated on the output; the downstream framer handles it.
- Fairness: a source that just finished cannot win the next arbitration while any other source is requesting. A sole requester wins back-to-back packets with one idle cycle between them.
- Simultaneous events:
  - If a last-beat transfer and a watchdog fire coincide, the transfer wins and timeout_stb stays 0. (A transfer clears the counter, so this cannot actually occur.)
  - An s_valid rising on a non-owner during XFER has no effect until IDLE.
- ptr wraps from NREQ-1 to 0. A non-power-of-two NREQ uses modulo arithmetic, never SRCW overflow.
- Reset asserted mid-packet aborts immediately to the reset values. No partial-packet tracking survives reset.
- Single-beat packets (s_valid and s_last on the first beat) are legal.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE/ST_XFER;
  - the clog2 helper function used to check SRCW;
  - the default TIMEOUT constant.
- One sub-module, rr_pick: purely combinational rotating-priority encoder.
  - Inputs: req[NREQ], ptr[SRCW].
  - Outputs: any, idx[SRCW].
  - Reusable by other schedulers in the design.
- Output mux, FSM and watchdog live in pkt_rr_sched.

Test Plan:
- Reset and idle: all s_valid=0 for 16 cycles -> busy=0, m_valid=0, s_ready=0, m_src=0 throughout.
- Alternating requesters: sources 0 and 2 each send repeated 3-beat packets, m_ready=1 -> output packets ordered 0,2,0,2. Each packet is 3 consecutive beats followed by one gap cycle. m_src matches the owner.
- All requesters, round-robin: s_valid=4'b1111, 2-beat packets -> grant order 0,1,2,3,0. No source appears twice in any window of 4 packets.
- Backpressure: owner 1 valid, m_ready toggles 1,0,1,0 over a 4-beat packet -> 4 transfers in 8 cycles, data order preserved, no timeout even with TIMEOUT=2.
- Watchdog: TIMEOUT=8, source 3 sends 1 beat with no last, then drops s_valid -> timeout_stb pulses 8 cycles after the last transfer, timeout_src=3. The next grant goes to source 0 if it is requesting.
- Reset mid-packet: assert rst_n=0 during beat 2 of source 1 -> outputs go to reset values within the same cycle. After release, arbitration starts from ptr=0.
